// File: rtl/tdc_code_monitor_if.sv
// rtl/tdc_code_monitor_if.sv - control, code and result bundle for the TDC code monitor
interface tdc_code_monitor_if #(
    parameter int NCH      = 3,
    parameter int NBIT     = 4,
    parameter int LOG2_WIN = 4
);
    logic                          start;
    logic                          abort;
    logic                          mode_cont;
    logic                          code_valid;
    logic [NCH*NBIT-1:0]           code;
    logic                          busy;
    logic                          done;
    logic                          res_valid;
    logic [NCH*NBIT-1:0]           mean_out;
    logic [NCH*NBIT-1:0]           min_out;
    logic [NCH*NBIT-1:0]           max_out;
    logic [NCH*(LOG2_WIN+1)-1:0]   sat_cnt;

    modport master (
        output start, abort, mode_cont, code_valid, code,
        input  busy, done, res_valid, mean_out, min_out, max_out, sat_cnt
    );

    modport slave (
        input  start, abort, mode_cont, code_valid, code,
        output busy, done, res_valid, mean_out, min_out, max_out, sat_cnt
    );
endinterface

// File: rtl/tdc_code_monitor.sv
// rtl/tdc_code_monitor.sv - windowed per-channel mean/min/max/saturation statistics of TDC codes
module tdc_code_monitor #(
    parameter int NCH      = 3,
    parameter int NBIT     = 4,
    parameter int LOG2_WIN = 4
) (
    input  logic              clk,
    input  logic              rstb,
    tdc_code_monitor_if.slave bus
);
    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = NBIT + LOG2_WIN;
    localparam int CW  = LOG2_WIN + 1;
    localparam logic [CW-1:0]          LAST_CNT = CW'(WIN - 1);
    localparam logic signed [NBIT-1:0] CODE_MAX = {1'b0, {(NBIT-1){1'b1}}};
    localparam logic signed [NBIT-1:0] CODE_MIN = {1'b1, {(NBIT-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]          cnt_q;
    logic signed [SW-1:0]   sum_q  [NCH];
    logic signed [SW-1:0]   sum_d  [NCH];
    logic signed [NBIT-1:0] min_q  [NCH];
    logic signed [NBIT-1:0] min_d  [NCH];
    logic signed [NBIT-1:0] max_q  [NCH];
    logic signed [NBIT-1:0] max_d  [NCH];
    logic [CW-1:0]          sat_q  [NCH];
    logic [CW-1:0]          sat_d  [NCH];
    logic signed [NBIT-1:0] code_k [NCH];
    logic signed [NBIT-1:0] mean_d [NCH];
    logic                   accept, last, init;

    logic                   done_q, res_valid_q;
    logic [NCH*NBIT-1:0]    mean_q, min_res_q, max_res_q;
    logic [NCH*CW-1:0]      sat_res_q;

    always_comb begin
        accept = (state_q == RUN) && !bus.abort && bus.code_valid;
        last   = accept && (cnt_q == LAST_CNT);
        init   = (state_q == IDLE) && bus.start && !bus.abort;
        for (int k = 0; k < NCH; k++) begin
            code_k[k] = bus.code[k*NBIT +: NBIT];
            sum_d[k]  = sum_q[k] + $signed({{LOG2_WIN{code_k[k][NBIT-1]}}, code_k[k]});
            min_d[k]  = (code_k[k] < min_q[k]) ? code_k[k] : min_q[k];
            max_d[k]  = (code_k[k] > max_q[k]) ? code_k[k] : max_q[k];
            sat_d[k]  = sat_q[k] + {{(CW-1){1'b0}},
                                    (code_k[k] == CODE_MAX) || (code_k[k] == CODE_MIN)};
            // Arithmetic shift floors toward -inf; the result always fits the code range.
            mean_d[k] = NBIT'(sum_d[k] >>> LOG2_WIN);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (init) state_d = RUN;
            RUN: begin
                if (bus.abort)                       state_d = IDLE;
                else if (last && !bus.mode_cont)     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            mean_q      <= '0;
            min_res_q   <= '0;
            max_res_q   <= '0;
            sat_res_q   <= '0;
            for (int k = 0; k < NCH; k++) begin
                sum_q[k] <= '0;
                min_q[k] <= '0;
                max_q[k] <= '0;
                sat_q[k] <= '0;
            end
        end else begin
            done_q <= last;
            // A completing window rearms the accumulators so continuous mode has no dead cycle.
            if (init || last) begin
                cnt_q <= '0;
                for (int k = 0; k < NCH; k++) begin
                    sum_q[k] <= '0;
                    min_q[k] <= CODE_MAX;
                    max_q[k] <= CODE_MIN;
                    sat_q[k] <= '0;
                end
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                for (int k = 0; k < NCH; k++) begin
                    sum_q[k] <= sum_d[k];
                    min_q[k] <= min_d[k];
                    max_q[k] <= max_d[k];
                    sat_q[k] <= sat_d[k];
                end
            end
            if (last) begin
                res_valid_q <= 1'b1;
                for (int k = 0; k < NCH; k++) begin
                    mean_q[k*NBIT +: NBIT]  <= mean_d[k];
                    min_res_q[k*NBIT +: NBIT] <= min_d[k];
                    max_res_q[k*NBIT +: NBIT] <= max_d[k];
                    sat_res_q[k*CW +: CW]   <= sat_d[k];
                end
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.mean_out  = mean_q;
    assign bus.min_out   = min_res_q;
    assign bus.max_out   = max_res_q;
    assign bus.sat_cnt   = sat_res_q;
endmodule

// File: tb/tb_tdc_code_monitor.sv
// tb/tb_tdc_code_monitor.sv - directed bench for tdc_code_monitor with a window-level reference model
module tb_tdc_code_monitor;
    localparam int NCH      = 2;
    localparam int NBIT     = 4;
    localparam int LOG2_WIN = 2;
    localparam int WIN      = 4;
    localparam int CW       = LOG2_WIN + 1;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    tdc_code_monitor_if #(.NCH(NCH), .NBIT(NBIT), .LOG2_WIN(LOG2_WIN)) bus();

    tdc_code_monitor #(.NCH(NCH), .NBIT(NBIT), .LOG2_WIN(LOG2_WIN)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit m_run;
    int m_n;
    int m_samp [NCH][WIN];
    bit exp_busy, exp_done, exp_rv;
    int exp_mean [NCH];
    int exp_min  [NCH];
    int exp_max  [NCH];
    int exp_sat  [NCH];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int code_of(input logic [NCH*NBIT-1:0] c, input int k);
        logic signed [NBIT-1:0] s;
        s = c[k*NBIT +: NBIT];
        return int'(s);
    endfunction

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic int f_mean(input int k); return code_of(bus.mean_out, k); endfunction
    function automatic int f_min(input int k);  return code_of(bus.min_out, k);  endfunction
    function automatic int f_max(input int k);  return code_of(bus.max_out, k);  endfunction
    function automatic int f_sat(input int k);
        logic [CW-1:0] v;
        v = bus.sat_cnt[k*CW +: CW];
        return int'(v);
    endfunction

    // Reference model: collects a window of samples and derives the statistics from them.
    initial begin
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) begin
                m_run = 0; m_n = 0;
                exp_busy = 0; exp_done = 0; exp_rv = 0;
                for (int k = 0; k < NCH; k++) begin
                    exp_mean[k] = 0; exp_min[k] = 0; exp_max[k] = 0; exp_sat[k] = 0;
                end
            end else begin
                exp_done = 0;
                if (!m_run) begin
                    if (bus.start && !bus.abort) begin
                        m_run = 1;
                        m_n = 0;
                    end
                end else if (bus.abort) begin
                    m_run = 0;
                end else if (bus.code_valid) begin
                    for (int k = 0; k < NCH; k++) m_samp[k][m_n] = code_of(bus.code, k);
                    m_n++;
                    if (m_n == WIN) begin
                        for (int k = 0; k < NCH; k++) begin
                            int s, mn, mx, st;
                            s = 0; st = 0; mn = m_samp[k][0]; mx = m_samp[k][0];
                            for (int i = 0; i < WIN; i++) begin
                                s += m_samp[k][i];
                                if (m_samp[k][i] < mn) mn = m_samp[k][i];
                                if (m_samp[k][i] > mx) mx = m_samp[k][i];
                                if (m_samp[k][i] == 7 || m_samp[k][i] == -8) st++;
                            end
                            exp_mean[k] = floor_div(s, WIN);
                            exp_min[k]  = mn;
                            exp_max[k]  = mx;
                            exp_sat[k]  = st;
                        end
                        exp_rv = 1;
                        exp_done = 1;
                        m_n = 0;
                        if (!bus.mode_cont) m_run = 0;
                    end
                end
                exp_busy = m_run;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("done", int'(bus.done), int'(exp_done));
            chk("res_valid", int'(bus.res_valid), int'(exp_rv));
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("mean[%0d]", k), f_mean(k), exp_mean[k]);
                chk($sformatf("min[%0d]", k),  f_min(k),  exp_min[k]);
                chk($sformatf("max[%0d]", k),  f_max(k),  exp_max[k]);
                chk($sformatf("sat[%0d]", k),  f_sat(k),  exp_sat[k]);
            end
        end
    end

    task automatic cyc(input bit st, input bit ab, input bit cv, input int c0, input int c1);
        logic [NBIT-1:0] a, b;
        a = c0[NBIT-1:0];
        b = c1[NBIT-1:0];
        bus.start = st; bus.abort = ab; bus.code_valid = cv;
        bus.code = {b, a};
        @(posedge clk); #1;
        bus.start = 0; bus.abort = 0; bus.code_valid = 0;
    endtask

    task automatic lit(input string nm, input int d, input int b, input int rv,
                       input int mn0, input int lo0, input int hi0, input int s0,
                       input int mn1, input int lo1, input int hi1, input int s1);
        chk({nm, " done"}, int'(bus.done), d);
        chk({nm, " busy"}, int'(bus.busy), b);
        chk({nm, " res_valid"}, int'(bus.res_valid), rv);
        chk({nm, " mean0"}, f_mean(0), mn0);
        chk({nm, " min0"},  f_min(0),  lo0);
        chk({nm, " max0"},  f_max(0),  hi0);
        chk({nm, " sat0"},  f_sat(0),  s0);
        chk({nm, " mean1"}, f_mean(1), mn1);
        chk({nm, " min1"},  f_min(1),  lo1);
        chk({nm, " max1"},  f_max(1),  hi1);
        chk({nm, " sat1"},  f_sat(1),  s1);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.mode_cont = 0; bus.code_valid = 0; bus.code = '0;
        #2 rstb = 0;
        #1 lit("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 rstb = 1;
        cyc(0, 0, 0, 0, 0);

        // single shot; start+valid together and start during RUN are both ignored
        cyc(1, 0, 1, 7, 7);
        cyc(0, 0, 1, 3, 0);
        cyc(1, 0, 1, -2, 0);
        cyc(0, 0, 1, 5, 0);
        chk("single pre-done", int'(bus.done), 0);
        cyc(0, 0, 1, 1, 0);
        lit("single", 1, 0, 1, 1, -2, 5, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("single done width", int'(bus.done), 0);

        // floor and saturation
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, -1, 7);
        cyc(0, 0, 1, -1, -8);
        cyc(0, 0, 1, -1, 7);
        cyc(0, 0, 1, -2, 0);
        lit("floor", 1, 0, 1, -2, -2, -1, 0, 1, -8, 7, 3);
        cyc(0, 0, 0, 0, 0);

        // continuous back-to-back windows
        bus.mode_cont = 1;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 2);
        lit("cont w1", 1, 1, 1, 1, 1, 1, 0, 2, 2, 2, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, -3, -1);
        chk("cont mid done", int'(bus.done), 0);
        cyc(0, 0, 1, -3, -1);
        lit("cont w2", 1, 1, 1, -3, -3, -3, 0, -1, -1, -1, 0);
        bus.mode_cont = 0;
        cyc(0, 1, 0, 0, 0);
        chk("cont abort busy", int'(bus.busy), 0);

        // abort together with a sample leaves the previous window published
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 5);
        cyc(0, 0, 1, 5, 5);
        cyc(0, 1, 1, 5, 5);
        lit("abort", 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("abort no done", int'(bus.done), 0);
        cyc(0, 0, 1, 6, 6);
        cyc(1, 1, 0, 0, 0);
        chk("start+abort idle busy", int'(bus.busy), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, -8);
        cyc(0, 0, 1, 2, -8);
        cyc(0, 0, 1, 2, -8);
        cyc(0, 0, 1, -4, -8);
        lit("after abort", 1, 0, 1, 0, -4, 2, 0, -8, -8, -8, 4);
        cyc(0, 0, 0, 0, 0);

        // asynchronous reset mid-window
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 3);
        cyc(0, 0, 1, 3, 3);
        #2 rstb = 0;
        #1 lit("async reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 rstb = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tdc_code_monitor.md
Name: tdc_code_monitor

Overview:
- Synthesizable multichannel statistics engine for TDC output codes. Generalises the single-channel, fixed 4-bit TDC comparison to NCH channels with parametrised code width and averaging window.
- Sits after the TDC bank in the bang-bang/digital PLL loop, or in a characterization harness.
- Per channel, it reports the windowed mean, min, max and saturation count. Supports single-shot and continuous modes with a start/done handshake.

Parameters:
- NCH, 3, number of TDC channels (dline, gosc, ideal, ...).
- NBIT, 4, signed TDC code width per channel.
- LOG2_WIN, 4, log2 of samples per window (WIN = 2^LOG2_WIN).

Ports:
- clk  in  1  sampling clock (TDC reference clock domain).
- rstb  in  1  asynchronous active-low reset.
- start  in  1  begin a window; sampled only in IDLE.
- abort  in  1  terminate the current window without publishing results.
- mode_cont  in  1  1 = continuous back-to-back windows; sampled when a window completes.
- code_valid  in  1  common strobe: all channel codes are valid this cycle.
- code  in  NCH*NBIT  signed codes, channel k at [k*NBIT +: NBIT].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a window completes.
- res_valid  out  1  results hold at least one completed window.
- mean_out  out  NCH*NBIT  per-channel floor(sum/WIN).
- min_out  out  NCH*NBIT  per-channel minimum code.
- max_out  out  NCH*NBIT  per-channel maximum code.
- sat_cnt  out  NCH*(LOG2_WIN+1)  per-channel count of full-scale codes.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE; busy, done and res_valid are 0; all result outputs are 0; sample counter and accumulators are 0.
- States: IDLE, RUN. DONE is not a separate state; done is a registered pulse.
- IDLE -> RUN: start=1 at a clock edge. At that edge, clear the sample counter (LOG2_WIN+1 bits), sums and saturation counters, set running min to +2^(NBIT-1)-1, and set running max to -2^(NBIT-1). A code_valid in the same cycle as start is ignored.
- RUN, per code_valid edge, for each channel:
  - sum += sign-extended code. Sum width is NBIT+LOG2_WIN signed, so there is no overflow.
  - Update running min and max.
  - sat += 1 if code equals -2^(NBIT-1) or 2^(NBIT-1)-1.
  - Sample counter += 1.
- Window completion: at the edge that accepts the WIN-th valid sample:
  - Result registers load the final statistics, including that sample, computed combinationally.
  - mean = arithmetic shift right of the sum by LOG2_WIN (floor toward -inf), truncated to NBIT. This is lossless, since the mean lies within code range.
  - done=1 for exactly one cycle following that edge; res_valid=1 and stays set until reset.
  - If mode_cont=1: remain in RUN and reinitialise the accumulators at the same edge. The next code_valid is sample 1 of the new window, with no dead cycle.
  - If mode_cont=0: go to IDLE; busy=0 from that edge.
- start while in RUN is ignored.
- abort=1 in RUN: go to IDLE at the next edge. Results, res_valid and done are untouched. Abort takes priority over a simultaneous window-completing code_valid, so no results are published.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins and the block stays in IDLE.
- code_valid in IDLE: ignored.
- Result outputs change only at window completion, so they are stable between done pulses.
- rstb asserted mid-window: immediate return to reset values, including results and res_valid.

Test Plan:
- Reset: assert rstb=0 mid-RUN -> busy=0, done=0, res_valid=0, and every mean/min/max/sat field reads 0 immediately, without waiting for a clock edge.
- Single-shot (NBIT=4, LOG2_WIN=2, NCH=2): start, then ch0 codes 3,-2,5,1 and ch1 codes 0,0,0,0 -> done pulses one cycle after the 4th valid edge. Expected results:
  - ch0: mean=1, min=-2, max=5, sat=0.
  - ch1: mean=0, min=0, max=0.
  - busy=0 afterwards.
- Floor/saturation: ch0 codes -1,-1,-1,-2 -> mean=-2 (sum -5), min=-2, max=-1. ch1 codes 7,-8,7,0 -> sat=3, mean=1, min=-8, max=7.
- Continuous: mode_cont=1, 8 consecutive valids (ch0 1,1,1,1 then -3,-3,-3,-3) -> done pulses twice, exactly 4 cycles apart. busy stays 1. Second mean=-3, min=max=-3, with no carry-over from window 1.
- Abort: after a completed window (mean=1), start a new one, give 2 valids, then abort together with the 3rd valid -> IDLE next edge, no done, results still mean=1 with res_valid=1. A code_valid in IDLE leaves the counters unchanged.
